// File: rtl/npu_clk_pkg.sv
// Shared types and default timing constants for the clock/reset infrastructure
// running from the 27 MHz board reference.
package npu_clk_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLL_RST   = 3'd4
    } rst_seq_state_t;

    // Defaults assume a 27 MHz reference: 270000 cycles is 10 ms.
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_N_RST          = 3;
    localparam int DEF_STAGE_GAP      = 16;
    localparam int DEF_LOCK_TIMEOUT   = 270000;
    localparam int DEF_PLL_RST_CYCLES = 64;
    localparam int DEF_CNT_W          = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level signal; output is the
// last stage. Reset clears every stage.
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Synchronizer shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Watches the rPLL lock, releases the PLL-domain resets in stages once lock is
// stable, re-resets on lock loss and pulses the PLL reset if lock never comes.
module pll_reset_sequencer
    import npu_clk_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int N_RST          = DEF_N_RST,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             clr_status,
    output logic             pll_reset,
    output logic [N_RST-1:0] rst_out,
    output logic             sys_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       state
);

    localparam int REL_CYCLES = N_RST * STAGE_GAP;
    localparam int TMR_MAX    = max_int(max_int(LOCK_TIMEOUT, STABLE_CYCLES),
                                        max_int(REL_CYCLES, PLL_RST_CYCLES));
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PRST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STB_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] REL_END   = TMR_W'(REL_CYCLES);

    rst_seq_state_t   state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pll_reset_q, pll_reset_d;
    logic [N_RST-1:0] rst_out_q, rst_out_d;
    logic             sys_ready_q, sys_ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] loss_count_q, loss_count_d;

    logic             lock_s;
    logic             loss_ev_s;
    logic [TMR_W-1:0] timer_inc_s;
    logic [TMR_W-1:0] rel_cnt_s;
    logic [N_RST-1:0] stage_rst_s;

    cdc_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(clk),
        .rst(rst),
        .d_i(pll_lock),
        .q_o(lock_s)
    );

    assign timer_inc_s = timer_q + TMR_W'(1);
    assign loss_ev_s   = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s;
    // Cycles since E0 as of the edge being computed; zero on the E0 edge itself.
    assign rel_cnt_s   = (state_q == ST_RELEASE) ? timer_inc_s : '0;

    // Stage i stays in reset until rel_cnt reaches i*STAGE_GAP.
    always_comb begin
        stage_rst_s = '1;
        for (int i = 0; i < N_RST; i++) begin
            if (rel_cnt_s >= TMR_W'(i * STAGE_GAP)) begin
                stage_rst_s[i] = 1'b0;
            end else begin
                stage_rst_s[i] = 1'b1;
            end
        end
    end

    // Next-state, timer and reset-output logic.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc_s;
        pll_reset_d = 1'b0;
        rst_out_d   = rst_out_q;
        sys_ready_d = sys_ready_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    state_d     = ST_PLL_RST;
                    timer_d     = '0;
                    pll_reset_d = 1'b1;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ST_PLL_RST: begin
                if (timer_q == PRST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    pll_reset_d = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STB_LAST) begin
                    state_d   = ST_RELEASE;
                    timer_d   = '0;
                    rst_out_d = stage_rst_s;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!lock_s) begin
                    state_d     = ST_WAIT_LOCK;
                    timer_d     = '0;
                    rst_out_d   = '1;
                    sys_ready_d = 1'b0;
                end else if (state_q == ST_RUN) begin
                    timer_d = timer_q;
                end else if (timer_inc_s == REL_END) begin
                    state_d     = ST_RUN;
                    timer_d     = '0;
                    rst_out_d   = stage_rst_s;
                    sys_ready_d = 1'b1;
                end else begin
                    rst_out_d = stage_rst_s;
                end
            end
            default: begin
                state_d     = ST_WAIT_LOCK;
                timer_d     = '0;
                rst_out_d   = '1;
                sys_ready_d = 1'b0;
            end
        endcase
    end

    // Sticky status; a loss on the same edge as a clear still records itself.
    always_comb begin
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
        if (loss_ev_s) begin
            lock_lost_d = 1'b1;
            if (clr_status) begin
                loss_count_d = CNT_W'(1);
            end else if (loss_count_q == {CNT_W{1'b1}}) begin
                loss_count_d = loss_count_q;
            end else begin
                loss_count_d = loss_count_q + CNT_W'(1);
            end
        end else if (clr_status) begin
            lock_lost_d  = 1'b0;
            loss_count_d = '0;
        end else begin
            lock_lost_d  = lock_lost_q;
            loss_count_d = loss_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WAIT_LOCK;
            timer_q      <= '0;
            pll_reset_q  <= 1'b0;
            rst_out_q    <= '1;
            sys_ready_q  <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pll_reset_q  <= pll_reset_d;
            rst_out_q    <= rst_out_d;
            sys_ready_q  <= sys_ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign rst_out    = rst_out_q;
    assign sys_ready  = sys_ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock traffic,
// checked each cycle against an edge-index based model of the sequencing rules.
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int NR     = 3;
    localparam int GAP    = 4;
    localparam int TMO    = 100;
    localparam int PRC    = 5;
    localparam int CW     = 8;

    localparam int PH_WAIT = 0, PH_STABLE = 1, PH_REL = 2, PH_RUN = 3, PH_PLL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_lock = 1'b0;
    logic          clr_status = 1'b0;
    logic          pll_reset;
    logic [NR-1:0] rst_out;
    logic          sys_ready;
    logic          lock_lost;
    logic [CW-1:0] loss_count;
    logic [2:0]    state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .N_RST(NR), .STAGE_GAP(GAP),
        .LOCK_TIMEOUT(TMO), .PLL_RST_CYCLES(PRC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .clr_status(clr_status),
        .pll_reset(pll_reset), .rst_out(rst_out), .sys_ready(sys_ready),
        .lock_lost(lock_lost), .loss_count(loss_count), .state(state)
    );

    // Model: phase plus the edge index at which the phase was entered.
    int            m_n = 0;
    int            m_phase = PH_WAIT;
    int            m_start = 0;
    int            m_cnt = 0;
    bit            m_lost = 1'b0;
    bit            m_valid = 1'b0;
    logic [SYNC-1:0] m_pipe = '0;
    bit            m_ls, m_loss;
    int            m_el;

    always @(posedge clk) begin
        m_n = m_n + 1;
        if (rst) begin
            m_phase = PH_WAIT; m_start = m_n; m_pipe = '0; m_lost = 1'b0; m_cnt = 0;
        end else begin
            m_ls   = m_pipe[SYNC-1];
            m_pipe = {m_pipe[SYNC-2:0], pll_lock};
            m_el   = m_n - m_start;
            m_loss = 1'b0;
            if (m_phase == PH_WAIT) begin
                if (m_ls) begin m_phase = PH_STABLE; m_start = m_n; end
                else if (m_el == TMO) begin m_phase = PH_PLL; m_start = m_n; end
            end else if (m_phase == PH_PLL) begin
                if (m_el == PRC) begin m_phase = PH_WAIT; m_start = m_n; end
            end else if (m_phase == PH_STABLE) begin
                if (!m_ls) begin m_phase = PH_WAIT; m_start = m_n; end
                else if (m_el == STABLE) begin m_phase = PH_REL; m_start = m_n; end
            end else begin
                if (!m_ls) begin m_loss = 1'b1; m_phase = PH_WAIT; m_start = m_n; end
                else if (m_phase == PH_REL && m_el == NR * GAP) begin m_phase = PH_RUN; m_start = m_n; end
            end
            if (m_loss) begin
                m_lost = 1'b1;
                m_cnt  = clr_status ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end else if (clr_status) begin
                m_lost = 1'b0; m_cnt = 0;
            end
        end
        m_valid = 1'b1;
    end

    logic [NR-1:0] exp_rst;
    always @(negedge clk) begin
        if (m_valid) begin
            exp_rst = '1;
            for (int i = 0; i < NR; i++) begin
                if (m_phase == PH_RUN || (m_phase == PH_REL && (m_n - m_start) >= i * GAP))
                    exp_rst[i] = 1'b0;
            end
            tests++;
            if (pll_reset !== (m_phase == PH_PLL) || rst_out !== exp_rst ||
                sys_ready !== (m_phase == PH_RUN) || lock_lost !== m_lost ||
                loss_count !== CW'(m_cnt) || state !== 3'(m_phase)) begin
                fails++;
                $display("FAIL model_cycle edge=%0d: dut pll_reset=%b rst_out=%b sys_ready=%b lock_lost=%b loss_count=%0d state=%0d; required %b %b %b %b %0d %0d",
                         m_n, pll_reset, rst_out, sys_ready, lock_lost, loss_count, state,
                         (m_phase == PH_PLL), exp_rst, (m_phase == PH_RUN), m_lost, m_cnt, m_phase);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic relock_to_e0(output int n);
        pll_lock = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (rst_out[0] == 1'b0) break;
        end
        if (rst_out[0] !== 1'b0) begin
            tests++; fails++;
            $display("FAIL relock_timeout: rst_out=%b after %0d cycles, required rst_out[0]=0", rst_out, n);
        end
    endtask

    task automatic lose();
        pll_lock = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  rise1, rise2, fall1, n, len;
    bit  prev, saw_pll;

    initial begin
        rst = 1'b1; pll_lock = 1'b0; clr_status = 1'b0;
        repeat (3) tick();
        check("reset_rst_out", rst_out, 3'b111);
        check("reset_state", state, 3'd0);
        check("reset_pll_reset", pll_reset, 1'b0);
        check("reset_loss_count", loss_count, 8'd0);

        // No lock: periodic PLL reset pulse.
        rst = 1'b0;
        rise1 = -1; rise2 = -1; fall1 = -1; prev = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (pll_reset && !prev) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            if (!pll_reset && prev && fall1 < 0) fall1 = k;
            prev = pll_reset;
        end
        check("pll_reset_first_rise", rise1, 100);
        check("pll_reset_width", fall1 - rise1, 5);
        check("pll_reset_period", rise2 - rise1, 105);

        // Normal bring-up.
        rst = 1'b1; tick();
        rst = 1'b0; pll_lock = 1'b1; saw_pll = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (pll_reset) saw_pll = 1'b1;
            if (k == 10) check("bringup_before_e0", rst_out, 3'b111);
            if (k == 11) check("bringup_e0", rst_out, 3'b110);
            if (k == 15) check("bringup_e0_plus4", rst_out, 3'b100);
            if (k == 19) check("bringup_e0_plus8", rst_out, 3'b000);
            if (k == 22) check("bringup_ready_early", sys_ready, 1'b0);
            if (k == 23) check("bringup_ready", sys_ready, 1'b1);
        end
        check("bringup_no_pll_reset", saw_pll, 1'b0);

        // Glitch during the stable window restarts the count.
        rst = 1'b1; pll_lock = 1'b0; tick();
        rst = 1'b0; pll_lock = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 5) pll_lock = 1'b0;
            if (k == 6) pll_lock = 1'b1;
            if (k == 11) check("glitch_no_early_release", rst_out, 3'b111);
            if (k == 16) check("glitch_before_e0", rst_out, 3'b111);
            if (k == 17) check("glitch_e0", rst_out, 3'b110);
            if (k == 17) check("glitch_lock_lost", lock_lost, 1'b0);
            if (k == 17) check("glitch_loss_count", loss_count, 8'd0);
            if (k == 29) check("glitch_ready", sys_ready, 1'b1);
        end

        // Loss in RUN, re-lock, then saturate the loss counter.
        pll_lock = 1'b0;
        tick(); tick();
        check("loss_not_yet", rst_out, 3'b000);
        tick();
        check("loss_rst_out", rst_out, 3'b111);
        check("loss_sys_ready", sys_ready, 1'b0);
        check("loss_lock_lost", lock_lost, 1'b1);
        check("loss_count_1", loss_count, 8'd1);
        relock_to_e0(n);
        check("relock_latency", n, 11);
        repeat (12) tick();
        check("relock_ready", sys_ready, 1'b1);
        for (int j = 0; j < 300; j++) begin
            lose();
            if (j == 200) check("loss_count_202", loss_count, 8'd202);
            relock_to_e0(n);
        end
        check("loss_count_saturated", loss_count, 8'd255);

        // Clear coinciding with a loss: the loss wins.
        repeat (12) tick();
        pll_lock = 1'b0;
        tick(); tick();
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("clr_loss_lock_lost", lock_lost, 1'b1);
        check("clr_loss_count", loss_count, 8'd1);
        relock_to_e0(n);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("clr_alone_lock_lost", lock_lost, 1'b0);
        check("clr_alone_count", loss_count, 8'd0);

        // Reset in the middle of the release sequence.
        lose();
        check("pre_rst_count", loss_count, 8'd1);
        relock_to_e0(n);
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrel_rst_out", rst_out, 3'b111);
        check("midrel_state", state, 3'd0);
        check("midrel_loss_count", loss_count, 8'd0);
        relock_to_e0(n);
        check("midrel_restart_latency", n, 11);

        // Random lock traffic with occasional clears and resets.
        for (int c = 0; c < 3000; c += len) begin
            pll_lock = 1'($urandom_range(0, 1));
            if (pll_lock) len = $urandom_range(1, 40);
            else if ($urandom_range(0, 7) == 0) len = $urandom_range(90, 130);
            else len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) begin
                clr_status = ($urandom_range(0, 15) == 0);
                rst = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        rst = 1'b0; clr_status = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
